// File: rtl/shift_add_mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package shift_add_mult_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/shift_add_mult_regs.sv
// Working register {carry, acc, mpr} of the multiplier.
// Load wins over add, and add wins over shift; the register holds when no control is set.
module mult_regs
  import shift_add_mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           load,
  input  logic           add,
  input  logic           shift,
  input  logic [W-1:0]   load_mpr,
  input  logic [W-1:0]   addend,
  output logic [2*W:0]   work
);

  logic [2*W:0] work_d, work_q;
  logic [W:0]   sum;

  always_comb begin
    sum    = {1'b0, work_q[2*W-1:W]} + {1'b0, addend};
    work_d = work_q;
    if (load) begin
      work_d = {{(W + 1){1'b0}}, load_mpr};
    end else if (add) begin
      // The adder result replaces both carry and acc. The old carry is always 0 here,
      // because every shift clears it.
      work_d = {sum, work_q[W-1:0]};
    end else if (shift) begin
      work_d = {1'b0, work_q[2*W:1]};
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      work_q <= '0;
    end else begin
      work_q <= work_d;
    end
  end

  assign work = work_q;

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier. Operands are converted to magnitudes,
// and the sign is re-applied to the product when it is loaded.
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            start,
  input  logic            signed_mode,
  input  logic [W-1:0]    multiplicand,
  input  logic [W-1:0]    multiplier,
  output logic            busy,
  output logic            done,
  output logic [2*W-1:0]  product
);

  localparam int CW = $clog2(W + 1);
  localparam int PW = 2 * W;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sign_q, sign_d;
  logic [W-1:0]   mag_a_q, mag_a_d;
  logic [PW-1:0]  product_q, product_d;
  logic [W-1:0]   a_mag, b_mag;
  logic [PW:0]    work;
  logic [PW-1:0]  shifted;
  logic           ld, do_add, do_shift;

  // Negating the most negative value wraps back to it. Read as unsigned, that is 2^(W-1).
  always_comb begin
    a_mag   = (signed_mode && multiplicand[W-1]) ? -multiplicand : multiplicand;
    b_mag   = (signed_mode && multiplier[W-1])   ? -multiplier   : multiplier;
    shifted = PW'(work >> 1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    mag_a_d   = mag_a_q;
    product_d = product_q;
    ld        = 1'b0;
    do_add    = 1'b0;
    do_shift  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ld      = 1'b1;
          sign_d  = signed_mode & (multiplicand[W-1] ^ multiplier[W-1]);
          mag_a_d = a_mag;
          cnt_d   = '0;
          state_d = b_mag[0] ? ADD : SHIFT;
        end
      end
      ADD: begin
        do_add  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        do_shift = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        // The final shift and the product load happen on the same edge,
        // so the product is built from the post-shift view of the register.
        if (cnt_d == CW'(W)) begin
          state_d   = DONE;
          product_d = sign_q ? -shifted : shifted;
        end else begin
          state_d = work[1] ? ADD : SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      mag_a_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      mag_a_q   <= mag_a_d;
      product_q <= product_d;
    end
  end

  mult_regs #(.W(W)) u_regs (
    .clk      (clk),
    .n_reset  (n_reset),
    .load     (ld),
    .add      (do_add),
    .shift    (do_shift),
    .load_mpr (b_mag),
    .addend   (mag_a_q),
    .work     (work)
  );

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult: a W=4 instance and a W=8 instance driven from hand-computed vectors.
module tb_shift_add_mult;
  import shift_add_mult_pkg::*;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        start4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  prod4;
  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  shift_add_mult #(.W(4)) u_dut4 (
    .clk(clk), .n_reset(n_reset), .start(start4), .signed_mode(sm4),
    .multiplicand(a4), .multiplier(b4), .busy(busy4), .done(done4), .product(prod4)
  );

  shift_add_mult #(.W(8)) u_dut8 (
    .clk(clk), .n_reset(n_reset), .start(start8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One operation from start pulse to done. If poke is non-zero, a second start with other
  // operands is driven on cycle poke, and the running operation must ignore it.
  task automatic run_op(input string tag, input int w, input logic sm, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp_p, input int exp_lat,
                        input int exp_adds, input int poke);
    int lat, busy_cnt, adds;
    logic [15:0] p;
    lat = 0; busy_cnt = 0; adds = 0; p = '0;
    @(negedge clk);
    if (w == 4) begin
      start4 = 1'b1; sm4 = sm; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    end
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      if (poke != 0 && n == poke) begin
        start4 = 1'b1; a4 = 4'h1; b4 = 4'h1; sm4 = ~sm;
      end
      if (poke != 0 && n == poke + 1) start4 = 1'b0;
      if ((w == 4) ? busy4 : busy8) busy_cnt++;
      if (w == 4 && u_dut4.state_q == ADD) adds++;
      if ((w == 4) ? done4 : done8) begin
        lat = n;
        p = (w == 4) ? {8'h00, prod4} : prod8;
        break;
      end
      @(negedge clk);
    end
    start4 = 1'b0;
    check_val({tag, " product"}, 32'(p), 32'(exp_p));
    check_val({tag, " latency"}, lat, exp_lat);
    check_val({tag, " busy cycles"}, busy_cnt, exp_lat);
    if (w == 4) check_val({tag, " add visits"}, adds, exp_adds);
    @(negedge clk);
    check_val({tag, " done after"}, 32'((w == 4) ? done4 : done8), 32'(0));
    check_val({tag, " busy after"}, 32'((w == 4) ? busy4 : busy8), 32'(0));
    check_val({tag, " product held"}, 32'((w == 4) ? {8'h00, prod4} : prod8), 32'(exp_p));
  endtask

  initial begin
    int pulses, first_at, second_at, shifts;
    logic [7:0] p1, p2;

    repeat (3) @(posedge clk);
    #1;
    check_val("reset busy4", 32'(busy4), 0);
    check_val("reset done4", 32'(done4), 0);
    check_val("reset prod4", 32'(prod4), 0);
    check_val("reset busy8", 32'(busy8), 0);
    check_val("reset done8", 32'(done8), 0);
    check_val("reset prod8", 32'(prod8), 0);
    #1 n_reset = 1'b1;

    run_op("u13x11",    4, 1'b0, 8'd13,  8'd11,  16'h008F, 8,  3, 0);
    run_op("u15x0",     4, 1'b0, 8'd15,  8'd0,   16'h0000, 5,  0, 0);
    run_op("u15x15",    4, 1'b0, 8'd15,  8'd15,  16'h00E1, 9,  4, 0);
    run_op("s-8x-8",    4, 1'b1, 8'h08,  8'h08,  16'h0040, 6,  1, 0);
    run_op("s-3x5",     4, 1'b1, 8'h0D,  8'h05,  16'h00F1, 7,  2, 0);
    run_op("s-5x0",     4, 1'b1, 8'h0B,  8'h00,  16'h0000, 5,  0, 0);
    run_op("u255x255",  8, 1'b0, 8'd255, 8'd255, 16'hFE01, 17, 0, 0);
    run_op("s-128x127", 8, 1'b1, 8'h80,  8'h7F,  16'hC080, 16, 0, 0);
    run_op("ignore",    4, 1'b0, 8'd13,  8'd11,  16'h008F, 8,  3, 3);

    // start held high: 3x5 finishes in cycle 7, then 5x6 is sampled on the IDLE edge and finishes in cycle 15
    @(negedge clk);
    sm4 = 1'b0; a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
    pulses = 0; first_at = 0; second_at = 0; p1 = '0; p2 = '0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (done4) begin
        pulses++;
        if (pulses == 1) begin
          first_at = n; p1 = prod4; a4 = 4'd5; b4 = 4'd6;
        end else begin
          second_at = n; p2 = prod4; start4 = 1'b0;
        end
      end
    end
    start4 = 1'b0;
    check_val("held pulses", pulses, 2);
    check_val("held first cycle", first_at, 7);
    check_val("held second cycle", second_at, 15);
    check_val("held first product", 32'(p1), 32'd15);
    check_val("held second product", 32'(p2), 32'd30);
    check_val("held idle after", 32'(busy4), 0);

    // 13x11 visits ADD, SHIFT, ADD, SHIFT, SHIFT, so the third SHIFT is cycle 5
    @(negedge clk);
    sm4 = 1'b0; a4 = 4'd13; b4 = 4'd11; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    shifts = 0;
    first_at = 0;
    for (int n = 1; n <= 10; n++) begin
      if (u_dut4.state_q == SHIFT) shifts++;
      if (shifts == 3) begin
        first_at = n;
        break;
      end
      @(negedge clk);
    end
    check_val("rst third shift cycle", first_at, 5);
    #1 n_reset = 1'b0;
    #1;
    check_val("rst async busy", 32'(busy4), 0);
    check_val("rst async done", 32'(done4), 0);
    check_val("rst async product", 32'(prod4), 0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done4) pulses++;
    end
    @(posedge clk);
    #2 n_reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done4) pulses++;
    end
    check_val("rst no done", pulses, 0);
    check_val("rst product stays 0", 32'(prod4), 0);

    run_op("after rst 6x7", 4, 1'b0, 8'd6, 8'd7, 16'd42, 8, 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
